// File: rtl/axis_cfg_pkt_player_if.sv
// Multi-channel AXI4-Stream bundle used by the configuration packet player.
//
// Handshake: on each channel c a beat transfers on a rising clk edge where
// tvalid[c] and tready[c] are both 1. Once the master raises tvalid[c], it
// holds tdata/tkeep/tlast for that channel steady until that transfer. The
// master never waits for tready before asserting tvalid. tready may change
// freely.
//
// Signals (channel c lives at [c*DATA_WIDTH +: DATA_WIDTH] / [c*KEEP_WIDTH +: KEEP_WIDTH]):
//   tdata   master->slave  NUM_CH*DATA_WIDTH  beat payload
//   tkeep   master->slave  NUM_CH*KEEP_WIDTH  byte enables
//   tvalid  master->slave  NUM_CH             beat valid
//   tlast   master->slave  NUM_CH             beat ends a packet
//   tready  slave->master  NUM_CH             sink can accept
interface axis_cfg_pkt_player_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_CH     = 2
);
  logic [NUM_CH*DATA_WIDTH-1:0] tdata;
  logic [NUM_CH*KEEP_WIDTH-1:0] tkeep;
  logic [NUM_CH-1:0]            tvalid;
  logic [NUM_CH-1:0]            tlast;
  logic [NUM_CH-1:0]            tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_cfg_pkt_player.sv
// Multi-channel AXI4-Stream configuration packet player.
// Beats are preloaded into an internal memory, each tagged with a destination
// channel and a last flag. A start pulse replays beats 0..num_beats-1 onto the
// tagged channel, honouring backpressure, and inserts a programmable gap after
// every packet.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data/wr_keep/
//   wr_last/wr_ch                   beat memory load port (ignored while busy)
//   start, num_beats, gap_cycles    replay control
//   abort                           stop at next packet boundary
//   busy, done, err_len, pkt_count  status
//   dbg_state                       current FSM state (state_t encoding)
//   m_axis                          NUM_CH output streams (master modport)
module axis_cfg_pkt_player #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 64,
  parameter int AW         = $clog2(DEPTH),
  parameter int CHW        = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [KEEP_WIDTH-1:0] wr_keep,
  input  logic                  wr_last,
  input  logic [CHW-1:0]        wr_ch,
  input  logic                  start,
  input  logic [AW:0]           num_beats,
  input  logic [15:0]           gap_cycles,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len,
  output logic [15:0]           pkt_count,
  output logic [2:0]            dbg_state,
  axis_cfg_pkt_player_if.master m_axis
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Beat memory (not reset).
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [KEEP_WIDTH-1:0] mem_keep [DEPTH];
  logic                  mem_last [DEPTH];
  logic [CHW-1:0]        mem_ch   [DEPTH];

  state_t                state_q, state_d;
  logic [AW-1:0]         ptr_q;
  logic [AW:0]           nb_q;
  logic [15:0]           gap_q;
  logic                  abort_pend_q;
  logic                  bad_start_q;

  // Registered read port: the beat currently presented on the stream.
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [KEEP_WIDTH-1:0] out_keep_q;
  logic                  out_last_q;
  logic [CHW-1:0]        out_ch_q;

  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic                  len_ok;
  logic                  is_final;
  logic                  cur_last;
  logic                  hs;
  logic                  abort_eff;

  assign len_ok    = (num_beats != '0) && (num_beats <= DEPTH_C);
  // ptr_q always indexes the beat held in the output registers.
  assign is_final  = ((AW+1)'(ptr_q) + (AW+1)'(1)) == nb_q;
  assign cur_last  = out_last_q | is_final;
  assign hs        = |(m_axis.tvalid & m_axis.tready);
  // An abort raised in the same cycle as the tlast handshake still counts.
  assign abort_eff = abort_pend_q | abort;

  assign busy      = (state_q == S_FETCH) || (state_q == S_SEND) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE) || bad_start_q;
  assign dbg_state = state_q;

  // Only the tagged channel sees tvalid; payload is fanned out to all lanes.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign m_axis.tvalid[c] = (state_q == S_SEND) && (out_ch_q == CHW'(c));
    assign m_axis.tlast[c]  = cur_last;
    assign m_axis.tdata[c*DATA_WIDTH +: DATA_WIDTH] = out_data_q;
    assign m_axis.tkeep[c*KEEP_WIDTH +: KEEP_WIDTH] = out_keep_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem_data[wr_addr] <= wr_data;
      mem_keep[wr_addr] <= wr_keep;
      mem_last[wr_addr] <= wr_last;
      mem_ch[wr_addr]   <= wr_ch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_addr = ptr_q;
    case (state_q)
      S_IDLE:  if (start && len_ok) state_d = S_FETCH;
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (hs) begin
          if (!cur_last) begin
            // Mid-packet: load the next beat on the same edge, no bubble.
            rd_en   = 1'b1;
            rd_addr = ptr_q + AW'(1);
          end else if (is_final || abort_eff) begin
            state_d = S_DONE;
          end else if (gap_cycles != 16'd0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      // The FETCH that follows GAP is one further idle cycle on the stream,
      // so a packet boundary costs gap_cycles+1 idle cycles in total.
      S_GAP: begin
        if (abort_eff)             state_d = S_DONE;
        else if (gap_q <= 16'd1)   state_d = S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      nb_q         <= '0;
      gap_q        <= '0;
      abort_pend_q <= 1'b0;
      bad_start_q  <= 1'b0;
      err_len      <= 1'b0;
      pkt_count    <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_ch_q     <= '0;
    end else begin
      bad_start_q <= (state_q == S_IDLE) && start && !len_ok;
      if ((state_q == S_IDLE) && start && !len_ok) err_len <= 1'b1;

      if ((state_q == S_IDLE) && start && len_ok) begin
        nb_q      <= num_beats;
        ptr_q     <= '0;
        pkt_count <= '0;
      end

      if (rd_en) begin
        out_data_q <= mem_data[rd_addr];
        out_keep_q <= mem_keep[rd_addr];
        out_last_q <= mem_last[rd_addr];
        out_ch_q   <= mem_ch[rd_addr];
      end

      if ((state_q == S_SEND) && hs) begin
        if (!is_final) ptr_q <= ptr_q + AW'(1);
        if (cur_last) begin
          if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
          gap_q <= gap_cycles;
        end
      end

      if (state_q == S_GAP) gap_q <= gap_q - 16'd1;

      if (busy && abort)         abort_pend_q <= 1'b1;
      else if (state_q == S_DONE) abort_pend_q <= 1'b0;
    end
  end

endmodule
